bnn_sequencer: RTL
==================

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 2047, SHALL set the per-stage watchdog limit in cycles (legal range 16..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new inference run.
REQ-005 abort  input  1  SHALL cancel any run and return to idle.
REQ-006 load_done  input  1  SHALL be the level from the pixel/weight loader: image buffered.
REQ-007 l1_done, l2_done, l3_done  input  1 each  SHALL be the sticky done levels from layers one to three.
REQ-008 state  output  3  SHALL be the stage code broadcast to all layer datapaths.
REQ-009 layer_clr  output  1  SHALL be a one-cycle pulse that re-arms every layer datapath; the layers' active-low reset is driven from its inverse.
REQ-010 busy  output  1  SHALL be high in LOAD, LAYER_1, LAYER_2 and LAYER_3.
REQ-011 result_valid  output  1  SHALL be high in DONE.
REQ-012 error  output  1  SHALL be high in ERROR.
REQ-013 err_stage  output  3  SHALL hold the state code of the stage that timed out.

Function
REQ-014 State encodings SHALL be: IDLE 000, LOAD 001, LAYER_1 010, LAYER_2 011, LAYER_3 100, DONE 101, ERROR 110; code 111 SHALL go to IDLE on the next edge.
REQ-015 All outputs SHALL be registered; state SHALL equal the current FSM state.
REQ-016 IDLE: start=1 -> LOAD next cycle, with layer_clr=1 during exactly the first LOAD cycle.
REQ-017 LOAD: load_done SHALL be ignored while layer_clr=1; afterwards load_done=1 -> LAYER_1 next cycle.
REQ-018 Stage advances: LAYER_1 on l1_done=1 -> LAYER_2; LAYER_2 on l2_done=1 -> LAYER_3; LAYER_3 on l3_done=1 -> DONE; each one cycle after the done level is sampled.
REQ-019 DONE: result_valid SHALL hold until start=1 (-> LOAD with layer_clr pulse, per REQ-016) or abort=1 (-> IDLE).
REQ-020 start SHALL be ignored in LOAD, LAYER_1..3 and ERROR.
REQ-021 abort=1 in any state except IDLE SHALL go to IDLE next cycle and pulse layer_clr for that one cycle.
REQ-022 abort=1 in IDLE SHALL have no effect.
REQ-023 start and abort high together: abort SHALL win.
REQ-024 A done input already high on stage entry SHALL advance after one cycle in that stage; stage dwell minimum is 1 cycle (LOAD: 2).
REQ-025 stage_cnt (16 bit, internal) SHALL clear on every state change and increment each cycle in LOAD/LAYER_1..3, saturating at TIMEOUT.
REQ-026 ERROR: error=1 SHALL hold; the only exit SHALL be abort=1 -> IDLE, which clears error and err_stage.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, busy=0, result_valid=0, error=0, err_stage=000, layer_clr=0 and stage_cnt=0, independent of clk.
REQ-028 Reset mid-run SHALL discard the run; after release, only a new start SHALL begin work, and it SHALL pulse layer_clr as in REQ-016.
REQ-029 The first rising edge after rst deasserts SHALL evaluate IDLE transitions normally.

Configuration
REQ-030 With macro BNN_WATCHDOG_EN defined: if stage_cnt reaches TIMEOUT-1 in a busy stage and that stage's done is low, the FSM SHALL go to ERROR next cycle and latch err_stage=that stage code; a done and a timeout on the same cycle SHALL resolve in favour of done.
REQ-031 With BNN_WATCHDOG_EN undefined: stage_cnt SHALL be absent, ERROR SHALL be unreachable, error SHALL be tied to 0 and err_stage to 000; busy stages SHALL wait indefinitely.

Verification
REQ-032 Normal run: reset, start pulse at cycle 0; load_done at cycle 5; l1_done at cycle 1600; l2_done at 2000; l3_done at 2100 -> state sequence 001,010,011,100,101 each one cycle after its trigger, layer_clr high only at cycle 1, result_valid=1 from cycle 2101.
REQ-033 Abort: abort=1 while state=010 -> state=000 and layer_clr=1 next cycle, busy=0; a later start begins a clean LOAD.
REQ-034 Watchdog (BNN_WATCHDOG_EN, TIMEOUT=16): hold l2_done=0 in LAYER_2 -> ERROR after 16 cycles, err_stage=011; start ignored; abort -> IDLE, error=0.
REQ-035 Simultaneous events: start and abort together in DONE -> IDLE; l1_done rising on the watchdog-limit cycle -> LAYER_2, not ERROR.
REQ-036 Async reset: assert rst between clock edges in LAYER_3 -> outputs at reset values before the next edge; stale l1_done=1 after a restart is not acted on while layer_clr=1.
REQ-037 Macro off: same stimulus as REQ-034 -> remains in 011 for 10000 cycles, error=0.

Source files
------------

// File: rtl/bnn_sequencer.sv
// Stage sequencer for a three-layer BNN: IDLE -> LOAD -> LAYER_1..3 -> DONE, all outputs registered.
// Define BNN_WATCHDOG_EN to add a per-stage watchdog that sends a stalled busy stage to ERROR.
module bnn_sequencer #(
   parameter int unsigned TIMEOUT = 2047
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       load_done,
   input  logic       l1_done,
   input  logic       l2_done,
   input  logic       l3_done,
   output logic [2:0] state,
   output logic       layer_clr,
   output logic       busy,
   output logic       result_valid,
   output logic       error,
   output logic [2:0] err_stage
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_LAYER_1 = 3'b010,
      S_LAYER_2 = 3'b011,
      S_LAYER_3 = 3'b100,
      S_DONE    = 3'b101,
      S_ERROR   = 3'b110,
      S_ILLEGAL = 3'b111
   } state_t;

   if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_timeout_range
      $error("bnn_sequencer: TIMEOUT must be within 16..65535");
   end

   state_t state_q, state_d;
   logic   layer_clr_q, layer_clr_d;
   logic   busy_q, busy_d;
   logic   result_valid_q, result_valid_d;
   logic   stage_done;
   logic   timeout;

   // load_done is masked during the re-arm cycle so a stale level from the previous run is ignored
   always_comb begin
      stage_done = 1'b0;
      case (state_q)
         S_LOAD:    stage_done = load_done & ~layer_clr_q;
         S_LAYER_1: stage_done = l1_done;
         S_LAYER_2: stage_done = l2_done;
         S_LAYER_3: stage_done = l3_done;
         default:   stage_done = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      layer_clr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d     = S_LOAD;
               layer_clr_d = 1'b1;
            end
         end
         S_LOAD:    if (stage_done) state_d = S_LAYER_1;
         S_LAYER_1: if (stage_done) state_d = S_LAYER_2;
         S_LAYER_2: if (stage_done) state_d = S_LAYER_3;
         S_LAYER_3: if (stage_done) state_d = S_DONE;
         S_DONE: begin
            if (start) begin
               state_d     = S_LOAD;
               layer_clr_d = 1'b1;
            end
         end
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_IDLE;
      endcase
      if (timeout) begin
         state_d = S_ERROR;
      end
      // abort outranks every other event, including a simultaneous start or timeout
      if (abort && state_q != S_IDLE) begin
         state_d     = S_IDLE;
         layer_clr_d = 1'b1;
      end
   end

   assign busy_d         = (state_d == S_LOAD)    || (state_d == S_LAYER_1) ||
                           (state_d == S_LAYER_2) || (state_d == S_LAYER_3);
   assign result_valid_d = (state_d == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         layer_clr_q    <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         layer_clr_q    <= layer_clr_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

`ifdef BNN_WATCHDOG_EN
   localparam logic [15:0] CNT_MAX = 16'(TIMEOUT);
   localparam logic [15:0] CNT_LIM = 16'(TIMEOUT - 1);

   logic [15:0] stage_cnt_q, stage_cnt_d;
   logic        error_q, error_d;
   logic [2:0]  err_stage_q, err_stage_d;
   logic        stage_busy;

   assign stage_busy = (state_q == S_LOAD)    || (state_q == S_LAYER_1) ||
                       (state_q == S_LAYER_2) || (state_q == S_LAYER_3);

   // a done sampled on the limit cycle wins over the timeout
   assign timeout = stage_busy && (stage_cnt_q >= CNT_LIM) && !stage_done;

   always_comb begin
      stage_cnt_d = stage_cnt_q;
      err_stage_d = err_stage_q;
      if (state_d != state_q) begin
         stage_cnt_d = 16'd0;
      end else if (stage_busy && stage_cnt_q < CNT_MAX) begin
         stage_cnt_d = stage_cnt_q + 16'd1;
      end
      if (state_d == S_ERROR && state_q != S_ERROR) begin
         err_stage_d = state_q;
      end else if (state_d == S_IDLE) begin
         err_stage_d = 3'b000;
      end
      error_d = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_cnt_q <= 16'd0;
         error_q     <= 1'b0;
         err_stage_q <= 3'b000;
      end else begin
         stage_cnt_q <= stage_cnt_d;
         error_q     <= error_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign error     = error_q;
   assign err_stage = err_stage_q;
`else
   assign timeout   = 1'b0;
   assign error     = 1'b0;
   assign err_stage = 3'b000;
`endif

   assign state        = state_q;
   assign layer_clr    = layer_clr_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;

endmodule
